uart_rx_monitor: RTL and testbench

//   Parametrised UART receiver/monitor for the PRV32 SOPC serial line (DUT uart_txd).

---
 rtl/uart_rx_monitor.sv | 210 +++++++++++++++++++++
 tb/tb_uart_rx_monitor.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_monitor.sv
// rtl/uart_rx_monitor.sv - UART receiver/monitor with error-flagged show-ahead FIFO
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   rxd                 serial input, idle high, asynchronous to clk
//   rd_valid/rd_ready   FIFO read handshake; head popped when both are high
//   rd_data/perr/ferr   head entry: data byte and its parity / framing error flags
//   fifo_level          entries held
//   busy                receiver is mid-frame
//   overrun             sticky, a completed frame was dropped on a full FIFO
//   clr_overrun         synchronous clear of overrun (set wins)
//   frame_cnt           completed frames, including errored and dropped ones
module uart_rx_monitor #(
   parameter int CLK_DIV    = 434,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          rxd,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_perr,
   output logic                          rd_ferr,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          overrun,
   input  logic                          clr_overrun,
   output logic [15:0]                   frame_cnt
);

   localparam int HALF = CLK_DIV / 2;
   localparam int TW   = $clog2(CLK_DIV);
   localparam int PW   = $clog2(FIFO_DEPTH);
   localparam int LW   = PW + 1;
   localparam int EW   = DATA_BITS + 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      PAR   = 3'd3,
      STOP  = 3'd4
   } state_t;

   state_t               state, state_nx;
   logic                 rxd_s1, rxd_s;
   logic [TW-1:0]        timer, timer_nx;
   logic [3:0]           bit_cnt, bit_nx;
   logic [DATA_BITS-1:0] shift, shift_nx;
   logic                 perr, perr_nx;
   logic                 ferr, ferr_nx;
   logic                 armed, armed_nx;
   logic                 push;

   // Two-flop synchroniser, preset to the idle level so reset never looks like a start bit.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rxd_s1 <= 1'b1;
         rxd_s  <= 1'b1;
      end else begin
         rxd_s1 <= rxd;
         rxd_s  <= rxd_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         timer   <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         armed   <= 1'b0;
      end else begin
         state   <= state_nx;
         timer   <= timer_nx;
         bit_cnt <= bit_nx;
         shift   <= shift_nx;
         perr    <= perr_nx;
         ferr    <= ferr_nx;
         armed   <= armed_nx;
      end
   end

   always_comb begin
      state_nx = state;
      timer_nx = timer + 1'b1;
      bit_nx   = bit_cnt;
      shift_nx = shift;
      perr_nx  = perr;
      ferr_nx  = ferr;
      armed_nx = armed;
      push     = 1'b0;
      case (state)
         IDLE: begin
            timer_nx = '0;
            // Only a 1->0 transition starts a frame; a line held low after a
            // framing error must first return high before we re-arm.
            if (rxd_s)
               armed_nx = 1'b1;
            else if (armed)
               state_nx = START;
         end
         START: begin
            if (timer == TW'(HALF - 1)) begin
               timer_nx = '0;
               if (rxd_s) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = DATA;
                  bit_nx   = '0;
                  perr_nx  = 1'b0;
                  ferr_nx  = 1'b0;
               end
            end
         end
         DATA: begin
            if (timer == TW'(CLK_DIV - 1)) begin
               timer_nx = '0;
               shift_nx = {rxd_s, shift[DATA_BITS-1:1]};
               if (bit_cnt == 4'(DATA_BITS - 1)) begin
                  bit_nx   = '0;
                  state_nx = (PARITY != 0) ? PAR : STOP;
               end else begin
                  bit_nx = bit_cnt + 4'd1;
               end
            end
         end
         PAR: begin
            if (timer == TW'(CLK_DIV - 1)) begin
               timer_nx = '0;
               perr_nx  = ((^shift) ^ rxd_s) != (PARITY == 1);
               state_nx = STOP;
            end
         end
         STOP: begin
            if (timer == TW'(CLK_DIV - 1)) begin
               timer_nx = '0;
               ferr_nx  = ferr | ~rxd_s;
               if (bit_cnt == 4'(STOP_BITS - 1)) begin
                  // Push mid-stop-bit so the next start edge can follow immediately.
                  push     = 1'b1;
                  bit_nx   = '0;
                  armed_nx = 1'b0;
                  state_nx = IDLE;
               end else begin
                  bit_nx = bit_cnt + 4'd1;
               end
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // FIFO
   logic [EW-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [LW-1:0] level;
   logic          full, pop, wr_en, drop;

   assign full     = (level == LW'(FIFO_DEPTH));
   assign rd_valid = (level != '0);
   assign pop      = rd_valid && rd_ready;
   assign wr_en    = push && (!full || pop);
   assign drop     = push && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= {shift_nx, perr_nx, ferr_nx};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         overrun   <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && !pop)
            level <= level + 1'b1;
         else if (pop && !wr_en)
            level <= level - 1'b1;
         if (drop)
            overrun <= 1'b1;
         else if (clr_overrun)
            overrun <= 1'b0;
         if (push)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Storage is not reset, so mask the head while the FIFO is empty.
   assign rd_data    = rd_valid ? mem[rd_ptr][EW-1:2] : '0;
   assign rd_perr    = rd_valid ? mem[rd_ptr][1] : 1'b0;
   assign rd_ferr    = rd_valid ? mem[rd_ptr][0] : 1'b0;
   assign fifo_level = level;

endmodule

// File: tb/tb_uart_rx_monitor.sv
// tb/tb_uart_rx_monitor.sv - directed bench for uart_rx_monitor (8N1 and 8E1 instances)
module tb_uart_rx_monitor;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rxd_n = 1'b1, rxd_e = 1'b1;
   logic       rdy_n = 1'b0, rdy_e = 1'b0;
   logic       clr_n = 1'b0, clr_e = 1'b0;

   logic       val_n, val_e, perr_n, perr_e, ferr_n, ferr_e;
   logic       busy_n, busy_e, ovr_n, ovr_e;
   logic [7:0] data_n, data_e;
   logic [2:0] lvl_n, lvl_e;
   logic [15:0] cnt_n, cnt_e;

   int vectors = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   uart_rx_monitor #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_n (
      .clk(clk), .rst(rst), .rxd(rxd_n), .rd_valid(val_n), .rd_ready(rdy_n),
      .rd_data(data_n), .rd_perr(perr_n), .rd_ferr(ferr_n), .fifo_level(lvl_n),
      .busy(busy_n), .overrun(ovr_n), .clr_overrun(clr_n), .frame_cnt(cnt_n)
   );

   uart_rx_monitor #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_dut_e (
      .clk(clk), .rst(rst), .rxd(rxd_e), .rd_valid(val_e), .rd_ready(rdy_e),
      .rd_data(data_e), .rd_perr(perr_e), .rd_ferr(ferr_e), .fifo_level(lvl_e),
      .busy(busy_e), .overrun(ovr_e), .clr_overrun(clr_e), .frame_cnt(cnt_e)
   );

   task automatic drive_bit(input logic sel, input logic b, input int cycles);
      if (sel) rxd_e = b; else rxd_n = b;
      repeat (cycles) @(negedge clk);
   endtask

   // sel: 0 = 8N1 instance, 1 = 8E1 instance. par < 0 means no parity bit.
   task automatic send(input logic sel, input logic [7:0] d, input int par, input logic stop_val);
      drive_bit(sel, 1'b0, DIV);
      for (int i = 0; i < 8; i++) drive_bit(sel, d[i], DIV);
      if (par >= 0) drive_bit(sel, par[0], DIV);
      drive_bit(sel, stop_val, DIV);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      rxd_n = 1'b1; rxd_e = 1'b1;
      rdy_n = 1'b0; rdy_e = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic pop_n;
      rdy_n = 1'b1;
      @(negedge clk);
      rdy_n = 1'b0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if ({val_n, data_n, perr_n, ferr_n, lvl_n, busy_n, ovr_n, cnt_n} !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_n: got %h required 0", {val_n, data_n, perr_n, ferr_n, lvl_n, busy_n, ovr_n, cnt_n});
      end
      vectors++;
      if ({val_e, data_e, perr_e, ferr_e, lvl_e, busy_e, ovr_e, cnt_e} !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_e: got %h required 0", {val_e, data_e, perr_e, ferr_e, lvl_e, busy_e, ovr_e, cnt_e});
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_back_to_back;
      logic [7:0] exp [2];
      exp[0] = 8'h55; exp[1] = 8'hA3;
      do_reset();
      send(1'b0, 8'h55, -1, 1'b1);
      send(1'b0, 8'hA3, -1, 1'b1);
      drive_bit(1'b0, 1'b1, 2 * DIV);
      vectors++;
      if (lvl_n !== 3'd2) begin
         miscompares++;
         $display("FAIL b2b_level: got %0d required 2", lvl_n);
      end
      for (int i = 0; i < 2; i++) begin
         vectors++;
         if ({val_n, data_n, perr_n, ferr_n} !== {1'b1, exp[i], 2'b00}) begin
            miscompares++;
            $display("FAIL b2b_entry%0d: got v=%b d=%h p=%b f=%b required v=1 d=%h p=0 f=0",
                     i, val_n, data_n, perr_n, ferr_n, exp[i]);
         end
         pop_n();
      end
      vectors++;
      if (val_n !== 1'b0 || cnt_n !== 16'd2) begin
         miscompares++;
         $display("FAIL b2b_end: got valid=%b frame_cnt=%0d required valid=0 frame_cnt=2", val_n, cnt_n);
      end
   endtask

   task automatic test_parity;
      do_reset();
      send(1'b1, 8'h07, 0, 1'b1);
      drive_bit(1'b1, 1'b1, DIV);
      vectors++;
      if ({val_e, data_e, perr_e, ferr_e} !== {1'b1, 8'h07, 1'b1, 1'b0}) begin
         miscompares++;
         $display("FAIL parity_bad: got v=%b d=%h p=%b f=%b required v=1 d=07 p=1 f=0", val_e, data_e, perr_e, ferr_e);
      end
      rdy_e = 1'b1; @(negedge clk); rdy_e = 1'b0;
      send(1'b1, 8'h07, 1, 1'b1);
      drive_bit(1'b1, 1'b1, DIV);
      vectors++;
      if ({val_e, data_e, perr_e, ferr_e} !== {1'b1, 8'h07, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL parity_good: got v=%b d=%h p=%b f=%b required v=1 d=07 p=0 f=0", val_e, data_e, perr_e, ferr_e);
      end
      vectors++;
      if (cnt_e !== 16'd2) begin
         miscompares++;
         $display("FAIL parity_cnt: got %0d required 2", cnt_e);
      end
   endtask

   task automatic test_framing;
      do_reset();
      send(1'b0, 8'h3C, -1, 1'b0);
      drive_bit(1'b0, 1'b1, 3 * DIV);
      vectors++;
      if ({lvl_n, data_n, perr_n, ferr_n} !== {3'd1, 8'h3C, 1'b0, 1'b1}) begin
         miscompares++;
         $display("FAIL ferr_entry: got lvl=%0d d=%h p=%b f=%b required lvl=1 d=3c p=0 f=1", lvl_n, data_n, perr_n, ferr_n);
      end
      vectors++;
      if (cnt_n !== 16'd1 || busy_n !== 1'b0) begin
         miscompares++;
         $display("FAIL ferr_cnt: got frame_cnt=%0d busy=%b required 1 and 0", cnt_n, busy_n);
      end
   endtask

   task automatic test_glitch;
      logic saw_busy;
      do_reset();
      saw_busy = 1'b0;
      rxd_n = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         saw_busy |= busy_n;
      end
      rxd_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         saw_busy |= busy_n;
      end
      repeat (3 * DIV) @(negedge clk);
      vectors++;
      if (saw_busy !== 1'b1) begin
         miscompares++;
         $display("FAIL glitch_busy_pulse: got %b required 1", saw_busy);
      end
      vectors++;
      if ({busy_n, lvl_n, cnt_n} !== 20'd0) begin
         miscompares++;
         $display("FAIL glitch_idle: got busy=%b lvl=%0d cnt=%0d required 0 0 0", busy_n, lvl_n, cnt_n);
      end
   endtask

   task automatic test_overrun;
      logic [7:0] v;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         v = 8'(i);
         send(1'b0, v, -1, 1'b1);
      end
      drive_bit(1'b0, 1'b1, DIV);
      vectors++;
      if ({lvl_n, ovr_n, data_n, cnt_n} !== {3'd4, 1'b1, 8'h01, 16'd5}) begin
         miscompares++;
         $display("FAIL ovr_state: got lvl=%0d ovr=%b head=%h cnt=%0d required 4 1 01 5", lvl_n, ovr_n, data_n, cnt_n);
      end
      for (int i = 1; i <= 4; i++) begin
         v = 8'(i);
         vectors++;
         if (val_n !== 1'b1 || data_n !== v) begin
            miscompares++;
            $display("FAIL ovr_pop%0d: got v=%b d=%h required v=1 d=%h", i, val_n, data_n, v);
         end
         pop_n();
      end
      vectors++;
      if (val_n !== 1'b0 || lvl_n !== 3'd0 || ovr_n !== 1'b1) begin
         miscompares++;
         $display("FAIL ovr_drained: got v=%b lvl=%0d ovr=%b required 0 0 1", val_n, lvl_n, ovr_n);
      end
      clr_n = 1'b1; @(negedge clk); clr_n = 1'b0;
      vectors++;
      if (ovr_n !== 1'b0) begin
         miscompares++;
         $display("FAIL ovr_clear: got %b required 0", ovr_n);
      end
   endtask

   task automatic test_reset_mid_frame;
      logic [7:0] d;
      do_reset();
      d = 8'hFF;
      drive_bit(1'b0, 1'b0, DIV);
      for (int i = 0; i < 3; i++) drive_bit(1'b0, d[i], DIV);
      drive_bit(1'b0, 1'b0, DIV / 2);
      vectors++;
      if (busy_n !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_busy: got %b required 1", busy_n);
      end
      rst = 1'b1;
      rxd_n = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3 * DIV) @(negedge clk);
      send(1'b0, 8'h9E, -1, 1'b1);
      drive_bit(1'b0, 1'b1, DIV);
      vectors++;
      if ({lvl_n, data_n, perr_n, ferr_n, cnt_n} !== {3'd1, 8'h9E, 2'b00, 16'd1}) begin
         miscompares++;
         $display("FAIL midrst_rx: got lvl=%0d d=%h p=%b f=%b cnt=%0d required 1 9e 0 0 1",
                  lvl_n, data_n, perr_n, ferr_n, cnt_n);
      end
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_parity();
      test_framing();
      test_glitch();
      test_overrun();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
